// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/memory-stage RAM port arbiter.
// Optional build macro: ARB_PERF_CNT_EN (adds stall/conflict performance counters).
package mem_port_arbiter_pkg;

    localparam int unsigned WordW = 32;

    typedef logic [WordW-1:0] word_t;

    // Access sequencing states
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } arb_state_e;

    // Which requester owns the in-flight access
    typedef enum logic {
        OwnF,
        OwnD
    } arb_owner_e;

endpackage

// File: rtl/arb_latency_timer.sv
// Fixed-latency countdown: load with LATENCY, count down once per cycle, done while count is 1.
module arb_latency_timer #(
    parameter int unsigned LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic done_o
);

    localparam int unsigned CntW = 3;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: reload on request, otherwise run down to zero and stop
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntW'(LATENCY);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between fetch (F) and memory stage (D) requesters.
// Optional build macro: ARB_PERF_CNT_EN adds perf_f_stall_cnt, perf_d_stall_cnt and
// perf_conflict_cnt outputs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned RAM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic [31:0]       f_rdata,
    output logic              f_valid,
    output logic              f_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    input  logic              d_misaligned,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_fault,
    output logic              d_stall,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_f_stall_cnt,
    output logic [31:0]       perf_d_stall_cnt,
    output logic [31:0]       perf_conflict_cnt,
`endif
    input  logic [31:0]       ram_rdata
);

    // Wide enough to hold STARVE_LIMIT, never zero bits
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 2);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    arb_state_e         state_q, state_d;
    arb_owner_e         owner_q, owner_d;
    logic               fault_q, fault_d;
    logic               we_q, we_d;
    logic [3:0]         be_q, be_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    word_t              wdata_q, wdata_d;
    word_t              f_rdata_q, f_rdata_d;
    word_t              d_rdata_q, d_rdata_d;
    logic [StarveW-1:0] starve_q, starve_d;

    logic timer_load;
    logic timer_done;
    logic force_f;

    // Only the word-address bits reach the RAM
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    arb_latency_timer #(
        .LATENCY (RAM_LATENCY)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (timer_load),
        .done_o (timer_done)
    );

    assign force_f = (STARVE_LIMIT != 0) && (starve_q == StarveMax);

    // Arbitration and access sequencing
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        fault_d    = fault_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f_rdata_d  = f_rdata_q;
        d_rdata_d  = d_rdata_q;
        starve_d   = starve_q;
        timer_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!f_req) begin
                    starve_d = '0;
                end
                if (!halt) begin
                    if (d_req && d_misaligned) begin
                        // Fault without touching the RAM
                        owner_d   = OwnD;
                        fault_d   = 1'b1;
                        d_rdata_d = '0;
                        state_d   = StDone;
                    end else if (f_req && (!d_req || force_f)) begin
                        owner_d    = OwnF;
                        fault_d    = 1'b0;
                        we_d       = 1'b0;
                        be_d       = 4'b0000;
                        addr_d     = f_addr[ADDR_W+1:2];
                        wdata_d    = '0;
                        starve_d   = '0;
                        timer_load = 1'b1;
                        state_d    = StIssue;
                    end else if (d_req) begin
                        owner_d    = OwnD;
                        fault_d    = 1'b0;
                        we_d       = d_we;
                        be_d       = d_we ? d_be : 4'b0000;
                        addr_d     = d_addr[ADDR_W+1:2];
                        wdata_d    = d_wdata;
                        timer_load = 1'b1;
                        state_d    = StIssue;
                        if (f_req && (starve_q != StarveMax)) begin
                            starve_d = starve_q + StarveW'(1);
                        end
                    end
                end
            end
            StIssue, StWait: begin
                if (timer_done) begin
                    if (owner_q == OwnF) begin
                        f_rdata_d = ram_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = ram_rdata;
                    end
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and access registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= OwnF;
            fault_q   <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            fault_q   <= fault_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            starve_q  <= starve_d;
        end
    end

    // RAM controls are only driven during ISSUE
    assign ram_en    = (state_q == StIssue);
    assign ram_we    = ram_en ? be_q : 4'b0000;
    assign ram_addr  = ram_en ? addr_q : '0;
    assign ram_wdata = ram_en ? wdata_q : '0;

    assign f_valid = (state_q == StDone) && (owner_q == OwnF);
    assign d_valid = (state_q == StDone) && (owner_q == OwnD);
    assign d_fault = d_valid && fault_q;
    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;
    assign f_stall = f_req && !f_valid;
    assign d_stall = d_req && !d_valid;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_f_q, perf_d_q, perf_c_q;
    logic        conflict;

    assign conflict = (state_q == StIdle) && !halt && f_req && d_req;

    // Free-running wrap-around event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_f_q <= '0;
            perf_d_q <= '0;
            perf_c_q <= '0;
        end else begin
            if (f_stall) begin
                perf_f_q <= perf_f_q + 32'd1;
            end
            if (d_stall) begin
                perf_d_q <= perf_d_q + 32'd1;
            end
            if (conflict) begin
                perf_c_q <= perf_c_q + 32'd1;
            end
        end
    end

    assign perf_f_stall_cnt  = perf_f_q;
    assign perf_d_stall_cnt  = perf_d_q;
    assign perf_conflict_cnt = perf_c_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RAM_LATENCY=1, one at RAM_LATENCY=3.
// Build with ARB_PERF_CNT_EN defined to also check the performance counters.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // ---------------- instance A: RAM_LATENCY = 1 ----------------
    logic        halt, f_req, d_req, d_we, d_misaligned;
    logic [31:0] f_addr, d_addr, d_wdata, f_rdata, d_rdata, ram_wdata, ram_rdata;
    logic [3:0]  d_be, ram_we;
    logic        f_valid, f_stall, d_valid, d_fault, d_stall, ram_en;
    logic [15:0] ram_addr;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_f, perf_d, perf_c;
`endif

    mem_port_arbiter #(
        .ADDR_W       (16),
        .RAM_LATENCY  (1),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt         (halt),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_rdata      (f_rdata),
        .f_valid      (f_valid),
        .f_stall      (f_stall),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_be         (d_be),
        .d_misaligned (d_misaligned),
        .d_rdata      (d_rdata),
        .d_valid      (d_valid),
        .d_fault      (d_fault),
        .d_stall      (d_stall),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
`ifdef ARB_PERF_CNT_EN
        .perf_f_stall_cnt  (perf_f),
        .perf_d_stall_cnt  (perf_d),
        .perf_conflict_cnt (perf_c),
`endif
        .ram_rdata    (ram_rdata)
    );

    // Byte-writable RAM, data visible during the ISSUE cycle (latency 1)
    logic [31:0] mem [0:255];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem[8'h00] <= 32'hF0F0_0001;
            mem[8'h10] <= 32'hDEAD_BEEF;
            mem[8'h20] <= 32'h1122_3344;
            mem_loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we[0]) mem[ram_addr[7:0]][7:0]   <= ram_wdata[7:0];
            if (ram_we[1]) mem[ram_addr[7:0]][15:8]  <= ram_wdata[15:8];
            if (ram_we[2]) mem[ram_addr[7:0]][23:16] <= ram_wdata[23:16];
            if (ram_we[3]) mem[ram_addr[7:0]][31:24] <= ram_wdata[31:24];
        end
    end

    assign ram_rdata = ram_en ? mem[ram_addr[7:0]] : 32'hxxxx_xxxx;

    // ---------------- instance B: RAM_LATENCY = 3 ----------------
    logic        b_halt, b_f_req, b_d_req;
    logic [31:0] b_f_addr, b_d_addr, b_f_rdata, b_d_rdata, b_ram_wdata, b_ram_rdata;
    logic [3:0]  b_ram_we;
    logic        b_f_valid, b_f_stall, b_d_valid, b_d_fault, b_d_stall, b_ram_en;
    logic [15:0] b_ram_addr, b_lat_addr;
    logic [1:0]  b_cnt;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] b_perf_f, b_perf_d, b_perf_c;
`endif

    mem_port_arbiter #(
        .ADDR_W       (16),
        .RAM_LATENCY  (3),
        .STARVE_LIMIT (4)
    ) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt         (b_halt),
        .f_req        (b_f_req),
        .f_addr       (b_f_addr),
        .f_rdata      (b_f_rdata),
        .f_valid      (b_f_valid),
        .f_stall      (b_f_stall),
        .d_req        (b_d_req),
        .d_we         (1'b0),
        .d_addr       (b_d_addr),
        .d_wdata      (32'h0),
        .d_be         (4'h0),
        .d_misaligned (1'b0),
        .d_rdata      (b_d_rdata),
        .d_valid      (b_d_valid),
        .d_fault      (b_d_fault),
        .d_stall      (b_d_stall),
        .ram_en       (b_ram_en),
        .ram_we       (b_ram_we),
        .ram_addr     (b_ram_addr),
        .ram_wdata    (b_ram_wdata),
`ifdef ARB_PERF_CNT_EN
        .perf_f_stall_cnt  (b_perf_f),
        .perf_d_stall_cnt  (b_perf_d),
        .perf_conflict_cnt (b_perf_c),
`endif
        .ram_rdata    (b_ram_rdata)
    );

    // Read data is valid only in the third cycle after ram_en (the last WAIT cycle)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_cnt <= 2'd0;
        end else if (b_ram_en) begin
            b_cnt      <= 2'd1;
            b_lat_addr <= b_ram_addr;
        end else if (b_cnt != 2'd0) begin
            b_cnt <= (b_cnt == 2'd2) ? 2'd0 : b_cnt + 2'd1;
        end
    end

    assign b_ram_rdata = (b_cnt == 2'd2) ? {16'hC0DE, b_lat_addr} : 32'hxxxx_xxxx;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_d_valid(input int budget);
        int n = 0;
        while (d_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("d_valid_wait", {31'b0, d_valid}, 32'd1);
    endtask

    task automatic wait_f_valid(input int budget);
        int n = 0;
        while (f_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("f_valid_wait", {31'b0, f_valid}, 32'd1);
    endtask

    // Requester protocol on instance A: while stalled, req and address must not change
    logic        f_prev_stall = 1'b0, d_prev_stall = 1'b0;
    logic [31:0] f_prev_addr = '0, d_prev_addr = '0;

    always @(posedge clk) begin
        if (d_prev_stall && !d_valid) begin
            checks++;
            assert (d_req === 1'b1 && d_addr === d_prev_addr) else begin
                errors++;
                $error("FAIL d_req_hold observed=%b/%h expected=1/%h", d_req, d_addr, d_prev_addr);
            end
        end
        if (f_prev_stall && !f_valid) begin
            checks++;
            assert (f_req === 1'b1 && f_addr === f_prev_addr) else begin
                errors++;
                $error("FAIL f_req_hold observed=%b/%h expected=1/%h", f_req, f_addr, f_prev_addr);
            end
        end
        d_prev_stall <= d_stall;
        d_prev_addr  <= d_addr;
        f_prev_stall <= f_stall;
        f_prev_addr  <= f_addr;
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          grants;
        int          fv_n;
        int          fv1;
        int          fv2;
        int          en_seen;
        logic [9:0]  seq;

        rst_n = 1'b0;
        halt = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_misaligned = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        b_halt = 1'b0; b_f_req = 1'b0; b_d_req = 1'b0; b_f_addr = '0; b_d_addr = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
        chk("rst_valids", {28'b0, f_valid, d_valid, d_fault, f_stall}, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_ram_addr", {16'b0, ram_addr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single load from byte 0x40 (word 0x10)
        d_req = 1'b1; d_addr = 32'h40;
        #1 chk("ld_stall_c0", {31'b0, d_stall}, 32'd1);
        tick();
        chk("ld_ram_en_c1", {31'b0, ram_en}, 32'd1);
        chk("ld_ram_addr_c1", {16'b0, ram_addr}, 32'h10);
        chk("ld_ram_we_c1", {28'b0, ram_we}, 32'd0);
        chk("ld_stall_c1", {30'b0, d_stall, d_valid}, 32'b10);
        tick();
        chk("ld_valid_c2", {29'b0, d_valid, d_stall, ram_en}, 32'b100);
        chk("ld_rdata_c2", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();
        chk("ld_valid_gone", {31'b0, d_valid}, 32'd0);
        chk("ld_rdata_hold", d_rdata, 32'hDEAD_BEEF);

        // Misaligned access: fault, no RAM access
        d_req = 1'b1; d_misaligned = 1'b1; d_addr = 32'h41;
        tick();
        chk("mis_no_ram_en", {31'b0, ram_en}, 32'd0);
        chk("mis_valid_fault", {30'b0, d_valid, d_fault}, 32'b11);
        chk("mis_rdata", d_rdata, 32'd0);
        d_req = 1'b0; d_misaligned = 1'b0;
        tick();
        chk("mis_fault_gone", {30'b0, d_valid, d_fault}, 32'd0);

        // Store low halfword to byte 0x80 (word 0x20)
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h0000_ABCD; d_addr = 32'h80;
        tick();
        chk("st_ram_en", {31'b0, ram_en}, 32'd1);
        chk("st_ram_we", {28'b0, ram_we}, 32'b0011);
        chk("st_ram_addr", {16'b0, ram_addr}, 32'h20);
        chk("st_ram_wdata", ram_wdata, 32'h0000_ABCD);
        tick();
        chk("st_valid", {30'b0, d_valid, ram_en}, 32'b10);
        chk("st_ram_we_off", {28'b0, ram_we}, 32'd0);
        chk("st_rdata_hold", d_rdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0; d_be = 4'b0000;
        tick();
        d_req = 1'b1;
        tick();
        tick();
        chk("st_readback", d_rdata, 32'h1122_ABCD);
        d_req = 1'b0;
        tick();

        // Continuous conflict: D,D,D,D,F repeating, F served every 15 cycles
        f_req = 1'b1; f_addr = 32'h0; d_req = 1'b1; d_addr = 32'h40;
        grants = 0; fv_n = 0; fv1 = 0; fv2 = 0; seq = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (ram_en) begin
                grants++;
                seq = {seq[8:0], ram_addr == 16'h10};
            end
            if (f_valid) begin
                fv_n++;
                if (fv_n == 1) fv1 = c;
                else           fv2 = c;
                if (fv_n == 2) f_req = 1'b0;
            end
        end
        chk("cf_grants", grants, 32'd10);
        chk("cf_order", {22'b0, seq}, {22'b0, 10'b11110_11110});
        chk("cf_fvalid_n", fv_n, 32'd2);
        chk("cf_fvalid_1", fv1, 32'd14);
        chk("cf_fvalid_2", fv2, 32'd29);
        chk("cf_f_rdata", f_rdata, 32'hF0F0_0001);
        wait_d_valid(6);
        d_req = 1'b0;
        tick();

        // Reset during ISSUE drops the access; held request is re-served
        d_req = 1'b1; d_addr = 32'h40;
        tick();
        chk("rm_ram_en_pre", {31'b0, ram_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rm_ram_en", {31'b0, ram_en}, 32'd0);
        chk("rm_ram_addr", {16'b0, ram_addr}, 32'd0);
        chk("rm_d_rdata", d_rdata, 32'd0);
        chk("rm_d_stall", {30'b0, d_stall, d_valid}, 32'b10);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rm_reissue", {31'b0, ram_en}, 32'd1);
        tick();
        chk("rm_valid", {31'b0, d_valid}, 32'd1);
        chk("rm_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();

        // F blocked by D traffic for 10 cycles
        f_req = 1'b1; f_addr = 32'h0; d_req = 1'b1; d_addr = 32'h40;
        repeat (10) tick();
        chk("pf_f_stall", {31'b0, f_stall}, 32'd1);
`ifdef ARB_PERF_CNT_EN
        chk("perf_f_stall", perf_f, 32'd10);
        chk("perf_d_stall", perf_d, 32'd9);
        chk("perf_conflict", perf_c, 32'd4);
`endif
        wait_d_valid(4);
        d_req = 1'b0;
        wait_f_valid(6);
        chk("pf_f_rdata", f_rdata, 32'hF0F0_0001);
        f_req = 1'b0;
        tick();

        // halt during WAIT on the latency-3 instance
        b_d_req = 1'b1; b_d_addr = 32'h100; b_f_req = 1'b1; b_f_addr = 32'h8;
        tick();
        chk("h_ram_en_c1", {31'b0, b_ram_en}, 32'd1);
        chk("h_ram_addr_c1", {16'b0, b_ram_addr}, 32'h40);
        b_halt = 1'b1;
        tick();
        chk("h_wait_c2", {30'b0, b_ram_en, b_d_valid}, 32'd0);
        tick();
        chk("h_wait_c3", {31'b0, b_d_valid}, 32'd0);
        tick();
        chk("h_valid_c4", {31'b0, b_d_valid}, 32'd1);
        chk("h_rdata_c4", b_d_rdata, 32'hC0DE_0040);
        b_d_req = 1'b0;
        en_seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (b_ram_en || b_f_valid) en_seen++;
        end
        chk("h_no_grant", en_seen, 32'd0);
        chk("h_f_stall", {31'b0, b_f_stall}, 32'd1);
        b_halt = 1'b0;
        tick();
        chk("h_f_issue", {31'b0, b_ram_en}, 32'd1);
        chk("h_f_addr", {16'b0, b_ram_addr}, 32'h2);
        tick();
        tick();
        chk("h_f_wait", {31'b0, b_f_valid}, 32'd0);
        tick();
        chk("h_f_valid", {31'b0, b_f_valid}, 32'd1);
        chk("h_f_rdata", b_f_rdata, 32'hC0DE_0002);
        b_f_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
